// File: rtl/multicycle_alu.sv
// multicycle_alu: KGPRisc ALU with a start/busy/done handshake.
// Logic, add/sub, compare and reserved opcodes finish in one cycle.
// Shifts step one bit per cycle, and MULU is an unsigned shift-add multiplier.
// Result and flags are registered and hold until the next done pulse.
module multicycle_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] result_hi,
    output logic             carryflag,
    output logic             signflag,
    output logic             overflowflag,
    output logic             zflag
);

    // The iteration counter must be able to hold WIDTH for MULU.
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;

    // Control and iteration state.
    logic [0:0]       r_state;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    // Registered outputs.
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_carry;
    logic             r_sign;
    logic             r_ovf;
    logic             r_zero;

    // Decode of the incoming request.
    logic               w_accept;
    logic               w_isShift;
    logic               w_isMulti;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_addFull;
    logic [WIDTH-1:0]   w_diff;

    // Single-cycle results.
    logic [WIDTH-1:0] w_quickRes;
    logic             w_quickCarry;
    logic             w_quickOvf;

    // One iteration step of the shifter and the multiplier.
    logic [WIDTH-1:0] w_shNext;
    logic             w_shOut;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH-1:0] w_mulHi;
    logic [WIDTH-1:0] w_mulLo;

    // Value written to the output registers on a done-producing edge.
    logic             w_write;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_carry;
    logic             w_ovf;

    assign w_accept  = start && (r_state == ST_IDLE);
    assign w_shamt   = operand1[SHAMT_W-1:0];
    assign w_isShift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                       (alu_control == OP_SRA);
    assign w_isMulti = (w_isShift && (w_shamt != '0)) || (alu_control == OP_MULU);
    assign w_addFull = {1'b0, operand0} + {1'b0, operand1};
    assign w_diff    = operand0 - operand1;

    assign w_mulSum  = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mulHi   = w_mulSum[WIDTH:1];
    assign w_mulLo   = {w_mulSum[0], r_b[WIDTH-1:1]};

    // Single-cycle datapath: everything except long shifts and MULU.
    always_comb begin
        w_quickRes   = '0;
        w_quickCarry = 1'b0;
        w_quickOvf   = 1'b0;
        case (alu_control)
            OP_ADD: begin
                w_quickRes   = w_addFull[WIDTH-1:0];
                w_quickCarry = w_addFull[WIDTH];
                w_quickOvf   = (operand0[WIDTH-1] == operand1[WIDTH-1]) &&
                               (w_addFull[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_SUB: begin
                w_quickRes   = w_diff;
                w_quickCarry = (operand0 < operand1);
                w_quickOvf   = (operand0[WIDTH-1] != operand1[WIDTH-1]) &&
                               (w_diff[WIDTH-1] != operand0[WIDTH-1]);
            end
            OP_AND:  w_quickRes = operand0 & operand1;
            OP_OR:   w_quickRes = operand0 | operand1;
            OP_XOR:  w_quickRes = operand0 ^ operand1;
            OP_NOR:  w_quickRes = ~(operand0 | operand1);
            OP_SLT:  w_quickRes[0] = ($signed(operand0) < $signed(operand1));
            OP_SLTU: w_quickRes[0] = (operand0 < operand1);
            OP_SLL, OP_SRL, OP_SRA: w_quickRes = operand0;
            default: w_quickRes = '0;
        endcase
    end

    // One-bit shift step on the working register, with the bit shifted out.
    always_comb begin
        w_shNext = r_a;
        w_shOut  = 1'b0;
        case (r_op)
            OP_SLL: begin
                w_shNext = {r_a[WIDTH-2:0], 1'b0};
                w_shOut  = r_a[WIDTH-1];
            end
            OP_SRL: begin
                w_shNext = {1'b0, r_a[WIDTH-1:1]};
                w_shOut  = r_a[0];
            end
            OP_SRA: begin
                w_shNext = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
                w_shOut  = r_a[0];
            end
            default: begin
                w_shNext = r_a;
                w_shOut  = 1'b0;
            end
        endcase
    end

    // Pick what gets written to the result registers and when.
    always_comb begin
        w_write = 1'b0;
        w_res   = w_quickRes;
        w_hi    = '0;
        w_carry = w_quickCarry;
        w_ovf   = w_quickOvf;
        if (r_state == ST_IDLE) begin
            w_write = w_accept && !w_isMulti;
        end else if (r_cnt == CNT_W'(1)) begin
            w_write = 1'b1;
            if (r_op == OP_MULU) begin
                w_res   = w_mulLo;
                w_hi    = w_mulHi;
                w_carry = |w_mulHi;
                w_ovf   = |w_mulHi;
            end else begin
                w_res   = w_shNext;
                w_carry = w_shOut;
                w_ovf   = 1'b0;
            end
        end
    end

    // FSM and iteration registers: load on accept of a multicycle op, step while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept && w_isMulti) begin
                r_state <= ST_RUN;
                r_op    <= alu_control;
                r_a     <= operand0;
                r_b     <= operand1;
                r_acc   <= '0;
                r_cnt   <= (alu_control == OP_MULU) ? CNT_W'(WIDTH) : CNT_W'(w_shamt);
            end
        end else begin
            if (r_op == OP_MULU) begin
                r_acc <= w_mulHi;
                r_b   <= w_mulLo;
            end else begin
                r_a <= w_shNext;
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // Output registers: updated only on done-producing edges, done pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_hi     <= '0;
            r_carry  <= 1'b0;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= w_write;
            if (w_write) begin
                r_result <= w_res;
                r_hi     <= w_hi;
                r_carry  <= w_carry;
                r_sign   <= w_res[WIDTH-1];
                r_ovf    <= w_ovf;
                r_zero   <= (w_res == '0);
            end
        end
    end

    assign busy         = (r_state == ST_RUN);
    assign done         = r_done;
    assign ALUResult    = r_result;
    assign result_hi    = r_hi;
    assign carryflag    = r_carry;
    assign signflag     = r_sign;
    assign overflowflag = r_ovf;
    assign zflag        = r_zero;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors with hand-computed results for a
// 32-bit and an 8-bit instance of multicycle_alu.
module tb_multicycle_alu;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;

    logic clk = 1'b0;
    logic rst_n;

    logic        aStart;
    logic [3:0]  aOp;
    logic [31:0] aOp0;
    logic [31:0] aOp1;
    logic        aBusy;
    logic        aDone;
    logic [31:0] aRes;
    logic [31:0] aHi;
    logic        aC, aS, aV, aZ;

    logic        bStart;
    logic [3:0]  bOp;
    logic [7:0]  bOp0;
    logic [7:0]  bOp1;
    logic        bBusy;
    logic        bDone;
    logic [7:0]  bRes;
    logic [7:0]  bHi;
    logic        bC, bS, bV, bZ;

    int nCompared   = 0;
    int nMismatched = 0;
    int doneCount;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dutWide (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (aStart),
        .alu_control  (aOp),
        .operand0     (aOp0),
        .operand1     (aOp1),
        .busy         (aBusy),
        .done         (aDone),
        .ALUResult    (aRes),
        .result_hi    (aHi),
        .carryflag    (aC),
        .signflag     (aS),
        .overflowflag (aV),
        .zflag        (aZ)
    );

    multicycle_alu #(.WIDTH(8), .SHAMT_W(3)) dutNarrow (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (bStart),
        .alu_control  (bOp),
        .operand0     (bOp0),
        .operand1     (bOp1),
        .busy         (bBusy),
        .done         (bDone),
        .ALUResult    (bRes),
        .result_hi    (bHi),
        .carryflag    (bC),
        .signflag     (bS),
        .overflowflag (bV),
        .zflag        (bZ)
    );

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request at the current negedge and wait (bounded) for done.
    // pokeAt > 0 pulses an extra ADD request that many cycles in, while busy.
    task automatic applyStimulus(input bit useB, input logic [3:0] op,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input int pokeAt, input int maxCyc,
                                 output int lat, output bit sawBusy);
        bit gotDone;
        if (useB) begin
            bStart = 1'b1; bOp = op; bOp0 = x[7:0]; bOp1 = y[7:0];
        end else begin
            aStart = 1'b1; aOp = op; aOp0 = x; aOp1 = y;
        end
        lat     = 0;
        sawBusy = 1'b0;
        gotDone = 1'b0;
        while (!gotDone && lat < maxCyc) begin
            @(negedge clk);
            lat++;
            aStart = 1'b0;
            bStart = 1'b0;
            if (useB ? bBusy : aBusy) sawBusy = 1'b1;
            if (useB ? bDone : aDone) begin
                gotDone = 1'b1;
            end else if (lat == pokeAt) begin
                if (useB) begin
                    bStart = 1'b1; bOp = OP_ADD; bOp0 = 8'd1; bOp1 = 8'd1;
                end else begin
                    aStart = 1'b1; aOp = OP_ADD; aOp0 = 32'd1; aOp1 = 32'd1;
                end
            end
        end
        aStart = 1'b0;
        bStart = 1'b0;
        if (!gotDone) lat = -1;
    endtask

    // Run one operation and check result, high word, flags {c,s,v,z}, latency and busy.
    task automatic applyAndCheck(input bit useB, input string tag, input logic [3:0] op,
                                 input logic [31:0] x, input logic [31:0] y, input int pokeAt,
                                 input logic [31:0] expRes, input logic [31:0] expHi,
                                 input logic [3:0] expFlags, input int expLat);
        int          lat;
        bit          sawBusy;
        logic [31:0] obsRes;
        logic [31:0] obsHi;
        logic [3:0]  obsFlags;
        applyStimulus(useB, op, x, y, pokeAt, expLat + 5, lat, sawBusy);
        obsRes   = useB ? {24'h0, bRes} : aRes;
        obsHi    = useB ? {24'h0, bHi} : aHi;
        obsFlags = useB ? {bC, bS, bV, bZ} : {aC, aS, aV, aZ};
        checkOutput({tag, ".res"}, 64'(obsRes), 64'(expRes));
        checkOutput({tag, ".hi"}, 64'(obsHi), 64'(expHi));
        checkOutput({tag, ".flags"}, 64'(obsFlags), 64'(expFlags));
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, ".sawBusy"}, 64'(sawBusy), 64'(expLat > 1));
    endtask

    // Directed test sequence.
    initial begin
        rst_n  = 1'b0;
        aStart = 1'b0; aOp = 4'd0; aOp0 = 32'd0; aOp1 = 32'd0;
        bStart = 1'b0; bOp = 4'd0; bOp0 = 8'd0;  bOp1 = 8'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset.wideRes", 64'(aRes), 64'h0);
        checkOutput("reset.wideHi", 64'(aHi), 64'h0);
        checkOutput("reset.wideCtl", 64'({aBusy, aDone, aC, aS, aV, aZ}), 64'h0);
        checkOutput("reset.narrowAll", 64'({bRes, bHi, bBusy, bDone, bC, bS, bV, bZ}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ADD, then done must drop the following cycle.
        applyAndCheck(0, "add10_15", OP_ADD, 32'd10, 32'd15, 0, 32'd25, 32'd0, 4'b0000, 1);
        @(negedge clk);
        checkOutput("add10_15.doneFall", 64'(aDone), 64'h0);

        // Opcode sweep on 10/15.
        applyAndCheck(0, "sw.add",  OP_ADD,  32'd10, 32'd15, 0, 32'd25,       32'd0, 4'b0000, 1);
        applyAndCheck(0, "sw.sub",  OP_SUB,  32'd10, 32'd15, 0, 32'hFFFFFFFB, 32'd0, 4'b1100, 1);
        applyAndCheck(0, "sw.and",  OP_AND,  32'd10, 32'd15, 0, 32'd10,       32'd0, 4'b0000, 1);
        applyAndCheck(0, "sw.or",   OP_OR,   32'd10, 32'd15, 0, 32'd15,       32'd0, 4'b0000, 1);
        applyAndCheck(0, "sw.xor",  OP_XOR,  32'd10, 32'd15, 0, 32'd5,        32'd0, 4'b0000, 1);
        applyAndCheck(0, "sw.nor",  OP_NOR,  32'd10, 32'd15, 0, 32'hFFFFFFF0, 32'd0, 4'b0100, 1);
        applyAndCheck(0, "sw.slt",  OP_SLT,  32'd10, 32'd15, 0, 32'd1,        32'd0, 4'b0000, 1);
        applyAndCheck(0, "sw.sltu", OP_SLTU, 32'd10, 32'd15, 0, 32'd1,        32'd0, 4'b0000, 1);
        applyAndCheck(0, "sw.sll",  OP_SLL,  32'd10, 32'd15, 0, 32'h00050000, 32'd0, 4'b0000, 16);
        applyAndCheck(0, "sw.srl",  OP_SRL,  32'd10, 32'd15, 0, 32'd0,        32'd0, 4'b0001, 16);
        applyAndCheck(0, "sw.sra",  OP_SRA,  32'd10, 32'd15, 0, 32'd0,        32'd0, 4'b0001, 16);
        applyAndCheck(0, "sw.mulu", OP_MULU, 32'd10, 32'd15, 0, 32'd150,      32'd0, 4'b0000, 33);
        applyAndCheck(0, "sw.rsv13", 4'd13,  32'd10, 32'd15, 0, 32'd0,        32'd0, 4'b0001, 1);

        // Arithmetic flag corners.
        applyAndCheck(0, "addOvf",   OP_ADD, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 32'd0, 4'b0110, 1);
        applyAndCheck(0, "addCarry", OP_ADD, 32'hFFFFFFFF, 32'd1, 0, 32'h00000000, 32'd0, 4'b1001, 1);
        applyAndCheck(0, "subOvf",   OP_SUB, 32'h80000000, 32'd1, 0, 32'h7FFFFFFF, 32'd0, 4'b0010, 1);

        // Shifts: a start pulsed mid-SRA must be ignored.
        applyAndCheck(0, "sraPoke", OP_SRA, 32'h80000000, 32'd4, 2, 32'hF8000000, 32'd0, 4'b0100, 5);
        doneCount = 0;
        repeat (3) begin
            @(negedge clk);
            if (aDone) doneCount++;
        end
        checkOutput("sraPoke.noExtraDone", 64'(doneCount), 64'h0);
        checkOutput("sraPoke.resHold", 64'(aRes), 64'hF8000000);
        applyAndCheck(0, "srl1",    OP_SRL, 32'h0000000F, 32'd1,  0, 32'h00000007, 32'd0, 4'b1000, 2);
        applyAndCheck(0, "sll1",    OP_SLL, 32'h80000001, 32'd1,  0, 32'h00000002, 32'd0, 4'b1000, 2);
        applyAndCheck(0, "sraZero", OP_SRA, 32'h80000000, 32'd32, 0, 32'h80000000, 32'd0, 4'b0100, 1);

        // MULU with nonzero high word, then a back-to-back ADD in the done cycle.
        applyAndCheck(0, "muluBig", OP_MULU, 32'hFFFFFFFF, 32'd2, 0, 32'hFFFFFFFE, 32'd1, 4'b1110, 33);
        applyAndCheck(0, "b2bAdd",  OP_ADD,  32'd10, 32'd15, 0, 32'd25, 32'd0, 4'b0000, 1);

        // Reset in the middle of a MULU aborts it with no done.
        aStart = 1'b1; aOp = OP_MULU; aOp0 = 32'd5; aOp1 = 32'd6;
        @(negedge clk);
        aStart = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("rstMid.busyBefore", 64'(aBusy), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstMid.res", 64'(aRes), 64'h0);
        checkOutput("rstMid.ctl", 64'({aHi, aBusy, aDone, aC, aS, aV, aZ}), 64'h0);
        doneCount = 0;
        repeat (2) begin
            @(negedge clk);
            if (aDone) doneCount++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (aDone) doneCount++;
        end
        checkOutput("rstMid.noDone", 64'(doneCount), 64'h0);
        applyAndCheck(0, "rstMid.add", OP_ADD, 32'd3, 32'd4, 0, 32'd7, 32'd0, 4'b0000, 1);

        // Narrow instance: WIDTH=8, SHAMT_W=3.
        applyAndCheck(1, "n.add",     OP_ADD,  32'd10,   32'd15, 0, 32'h19, 32'h00, 4'b0000, 1);
        applyAndCheck(1, "n.addOvf",  OP_ADD,  32'h7F,   32'd1,  0, 32'h80, 32'h00, 4'b0110, 1);
        applyAndCheck(1, "n.sub",     OP_SUB,  32'd10,   32'd15, 0, 32'hFB, 32'h00, 4'b1100, 1);
        applyAndCheck(1, "n.sra4",    OP_SRA,  32'h80,   32'd4,  0, 32'hF8, 32'h00, 4'b0100, 5);
        applyAndCheck(1, "n.srl9",    OP_SRL,  32'h81,   32'd9,  0, 32'h40, 32'h00, 4'b1000, 2);
        applyAndCheck(1, "n.rsv15",   4'd15,   32'd10,   32'd15, 0, 32'h00, 32'h00, 4'b0001, 1);
        applyAndCheck(1, "n.muluFF2", OP_MULU, 32'hFF,   32'd2,  0, 32'hFE, 32'h01, 4'b1110, 9);
        applyAndCheck(1, "n.muluFFFF", OP_MULU, 32'hFF,  32'hFF, 0, 32'h01, 32'hFE, 4'b1010, 9);

        bStart = 1'b1; bOp = OP_MULU; bOp0 = 8'h0F; bOp1 = 8'h0F;
        @(negedge clk);
        bStart = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("n.rstMid.all", 64'({bRes, bHi, bBusy, bDone, bC, bS, bV, bZ}), 64'h0);
        doneCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bDone) doneCount++;
        end
        checkOutput("n.rstMid.noDone", 64'(doneCount), 64'h0);
        applyAndCheck(1, "n.rstMid.add", OP_ADD, 32'd3, 32'd4, 0, 32'h07, 32'h00, 4'b0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
